// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and clear-engine state encoding for regfile_mp
package regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;
    localparam int unsigned ZERO_REG = 0;
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_t;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write, issue and clear signals of the multi-port register file
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NUM_RD = 2
);
    localparam int AW = $clog2(DEPTH);
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pend;
    logic                     wa_en;
    logic [AW-1:0]            wa_addr;
    logic [DATA_W-1:0]        wa_data;
    logic                     wb_en;
    logic [AW-1:0]            wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     iss_en;
    logic [AW-1:0]            iss_addr;
    logic                     clr_req;
    logic                     clr_busy;
    modport master (
        output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, iss_en, iss_addr, clr_req,
        input  rd_data, rd_pend, clr_busy
    );
    modport slave (
        input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, iss_en, iss_addr, clr_req,
        output rd_data, rd_pend, clr_busy
    );
endinterface

// File: rtl/regfile_bypass_mux.sv
// regfile_bypass_mux: one read port's forwarding select, port B over port A over stored data
module regfile_bypass_mux #(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              wa_ok,
    input  logic [AW-1:0]     wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_ok,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data
);
    logic hit_a, hit_b;
    assign hit_a = (BYPASS != 0) && wa_ok && (wa_addr == addr);
    assign hit_b = (BYPASS != 0) && wb_ok && (wb_addr == addr);
    assign data  = hit_b ? wb_data : hit_a ? wa_data : stored;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with bypass, pending scoreboard and bulk clear
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] R0   = AW'(ZERO_REG);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH-1:1];
    logic [DEPTH-1:1]  pend;
    clr_state_t        state;
    logic [AW-1:0]     idx;
    logic              busy, wa_ok, wb_ok, iss_ok;

    assign busy   = (state == CLEAR);
    assign wa_ok  = !busy && bus.wa_en && (bus.wa_addr != R0);
    assign wb_ok  = !busy && bus.wb_en && (bus.wb_addr != R0);
    assign iss_ok = !busy && bus.iss_en && (bus.iss_addr != R0);
    assign bus.clr_busy = busy;

    // array: clear walk owns the write path while busy, otherwise B is applied after A so it wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++) mem[i] <= '0;
        end else if (busy) begin
            mem[idx] <= '0;
        end else begin
            if (wa_ok) mem[bus.wa_addr] <= bus.wa_data;
            if (wb_ok) mem[bus.wb_addr] <= bus.wb_data;
        end
    end

    // scoreboard: writes clear, issue sets last so it wins, clear start wipes everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else if (!busy && bus.clr_req) begin
            pend <= '0;
        end else begin
            if (wa_ok) pend[bus.wa_addr] <= 1'b0;
            if (wb_ok) pend[bus.wb_addr] <= 1'b0;
            if (iss_ok) pend[bus.iss_addr] <= 1'b1;
        end
    end

    // clear engine: walks idx from 1 to DEPTH-1, one register per cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else if (busy) begin
            idx <= idx + AW'(1);
            if (idx == LAST) state <= IDLE;
        end else if (bus.clr_req) begin
            state <= CLEAR;
            idx   <= AW'(1);
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     a;
        logic [DATA_W-1:0] stored;
        assign a      = bus.rd_addr[k*AW +: AW];
        assign stored = (a == R0) ? '0 : mem[a];
        assign bus.rd_pend[k] = (a != R0) && pend[a];
        regfile_bypass_mux #(.DATA_W(DATA_W), .AW(AW), .BYPASS(BYPASS)) u_mux (
            .addr    (a),
            .stored  (stored),
            .wa_ok   (wa_ok),
            .wa_addr (bus.wa_addr),
            .wa_data (bus.wa_data),
            .wb_ok   (wb_ok),
            .wb_addr (bus.wb_addr),
            .wb_data (bus.wb_data),
            .data    (bus.rd_data[k*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized scoreboard bench for regfile_mp with bypass on and off
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int D  = 32;
    localparam int NR = 2;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .DEPTH(D), .NUM_RD(NR)) bus ();
    regfile_mp_if #(.DATA_W(DW), .DEPTH(D), .NUM_RD(NR)) bus0 ();

    regfile_mp #(.DATA_W(DW), .DEPTH(D), .NUM_RD(NR), .BYPASS(1)) dut (.clk(clk), .reset(reset), .bus(bus));
    regfile_mp #(.DATA_W(DW), .DEPTH(D), .NUM_RD(NR), .BYPASS(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    assign bus0.rd_addr  = bus.rd_addr;
    assign bus0.wa_en    = bus.wa_en;
    assign bus0.wa_addr  = bus.wa_addr;
    assign bus0.wa_data  = bus.wa_data;
    assign bus0.wb_en    = bus.wb_en;
    assign bus0.wb_addr  = bus.wb_addr;
    assign bus0.wb_data  = bus.wb_data;
    assign bus0.iss_en   = bus.iss_en;
    assign bus0.iss_addr = bus.iss_addr;
    assign bus0.clr_req  = bus.clr_req;

    typedef struct {
        string       name;
        int          port;
        logic [31:0] d1;
        logic [31:0] d0;
        logic        p;
        logic        busy;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    logic [31:0] m [D];
    bit          pm [D];
    int          busy_left;
    int          clr_next;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", n, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (q.size() != 0) begin
            e = q.pop_front();
            chk({e.name, "_data_byp"}, bus.rd_data[e.port*DW +: DW], e.d1);
            chk({e.name, "_data_nobyp"}, bus0.rd_data[e.port*DW +: DW], e.d0);
            chk({e.name, "_pend"}, {31'd0, bus.rd_pend[e.port]}, {31'd0, e.p});
            chk({e.name, "_pend_nobyp"}, {31'd0, bus0.rd_pend[e.port]}, {31'd0, e.p});
            chk({e.name, "_busy"}, {31'd0, bus.clr_busy}, {31'd0, e.busy});
            chk({e.name, "_busy_nobyp"}, {31'd0, bus0.clr_busy}, {31'd0, e.busy});
        end
    end

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            m[i] = '0;
            pm[i] = 1'b0;
        end
        busy_left = 0;
        clr_next = 0;
    endtask

    function automatic logic [31:0] exp_rd(input int a, input bit byp);
        if (a == 0) return '0;
        if (byp && busy_left == 0) begin
            if (bus.wb_en && int'(bus.wb_addr) == a) return bus.wb_data;
            if (bus.wa_en && int'(bus.wa_addr) == a) return bus.wa_data;
        end
        return m[a];
    endfunction

    task automatic push_checks(input string n);
        exp_t e;
        int a;
        for (int k = 0; k < NR; k++) begin
            a = int'(bus.rd_addr[k*AW +: AW]);
            e.name = n;
            e.port = k;
            e.d1 = exp_rd(a, 1'b1);
            e.d0 = exp_rd(a, 1'b0);
            e.p = pm[a];
            e.busy = (busy_left > 0);
            q.push_back(e);
        end
    endtask

    task automatic update_model();
        if (reset) begin
            model_reset();
        end else if (busy_left > 0) begin
            m[clr_next] = '0;
            clr_next++;
            busy_left--;
        end else begin
            if (bus.wa_en && bus.wa_addr != 0) begin
                m[bus.wa_addr] = bus.wa_data;
                pm[bus.wa_addr] = 1'b0;
            end
            if (bus.wb_en && bus.wb_addr != 0) begin
                m[bus.wb_addr] = bus.wb_data;
                pm[bus.wb_addr] = 1'b0;
            end
            if (bus.iss_en && bus.iss_addr != 0) pm[bus.iss_addr] = 1'b1;
            if (bus.clr_req) begin
                for (int i = 0; i < D; i++) pm[i] = 1'b0;
                busy_left = D - 1;
                clr_next = 1;
            end
        end
    endtask

    task automatic step(input string n);
        push_checks(n);
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic idle();
        bus.wa_en = 1'b0;
        bus.wa_addr = '0;
        bus.wa_data = '0;
        bus.wb_en = 1'b0;
        bus.wb_addr = '0;
        bus.wb_data = '0;
        bus.iss_en = 1'b0;
        bus.iss_addr = '0;
        bus.clr_req = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        bus.rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic fill();
        for (int r = 1; r < D; r++) begin
            idle();
            bus.wb_en = 1'b1;
            bus.wb_addr = AW'(r);
            bus.wb_data = $urandom | 32'h1;
            set_rd(r, r - 1);
            step("fill");
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        set_rd(0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        set_rd(5, 31);
        step("reset");
        set_rd(31, 5);
        step("reset");

        bus.wa_en = 1'b1; bus.wa_addr = 5'd3; bus.wa_data = 32'h1234;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hBEEF;
        set_rd(3, 3);
        step("wr_prio");
        idle();
        step("wr_prio_next");

        bus.wa_en = 1'b1; bus.wa_addr = 5'd0; bus.wa_data = 32'hFFFF_FFFF;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
        set_rd(0, 0);
        step("r0_wr");
        idle();
        step("r0_next");

        set_rd(7, 7);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
        step("iss7");
        idle();
        step("iss7_pend");
        bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
        bus.wa_en = 1'b1; bus.wa_addr = 5'd7; bus.wa_data = 32'd5;
        step("iss7_wr");
        idle();
        bus.wa_en = 1'b1; bus.wa_addr = 5'd7; bus.wa_data = 32'd6;
        step("wr7");
        idle();
        step("wr7_unpend");

        for (int c = 0; c < 400; c++) begin
            bus.wa_en = 1'($urandom);
            bus.wa_addr = AW'($urandom_range(0, 7));
            bus.wa_data = $urandom;
            bus.wb_en = 1'($urandom);
            bus.wb_addr = AW'($urandom_range(0, 7));
            bus.wb_data = $urandom;
            bus.iss_en = 1'($urandom);
            bus.iss_addr = AW'($urandom_range(0, 7));
            set_rd($urandom_range(0, 7), $urandom_range(0, 7));
            step("rand");
        end
        idle();

        fill();
        bus.clr_req = 1'b1;
        set_rd(1, 9);
        step("clr_start");
        idle();
        for (int c = 1; c <= 33; c++) begin
            idle();
            if (c == 5) begin
                bus.wa_en = 1'b1; bus.wa_addr = 5'd9; bus.wa_data = 32'hDEAD;
                bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
                bus.clr_req = 1'b1;
            end
            set_rd((c % 2 == 0) ? 1 : $urandom_range(0, 31), 9);
            step("clr_walk");
        end
        idle();
        for (int r = 0; r < D; r += 2) begin
            set_rd(r, r + 1);
            step("clr_done");
        end

        fill();
        bus.clr_req = 1'b1;
        step("clr2_start");
        idle();
        for (int c = 1; c < 10; c++) begin
            set_rd(c, 31 - c);
            step("clr2_walk");
        end
        reset = 1'b1;
        model_reset();
        for (int r = 0; r < D; r += 2) begin
            set_rd(r, r + 1);
            step("rst_mid_clr");
        end
        reset = 1'b0;
        bus.wa_en = 1'b1; bus.wa_addr = 5'd4; bus.wa_data = 32'hA5A5_0F0F;
        set_rd(4, 9);
        step("post_rst_wr");
        idle();
        step("post_rst_rd");

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
